lc9_sequencer: RTL and testbench

Parametrised, programmable control sequencer for the LogicCore9 datapath. It replaces a hard-decoded state-to-control mapping with an internal step counter and a writable microcode store. The store holds NUM_PROGS programs of up to STEPS control words each. The block sits between the operation-request logic and the datapath: it drives mux selects, register load enables and the ALU opcode, and it reports completion over a start/busy/done handshake.

---
 rtl/lc9_seq_pkg.sv | 27 ++
 rtl/lc9_ucode_store.sv | 31 +++
 rtl/lc9_sequencer.sv | 134 +++++++++++++
 tb/tb_lc9_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc9_seq_pkg.sv
// rtl/lc9_seq_pkg.sv - shared types and field offsets for the lc9 sequencer
package lc9_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REGS = 5;
    localparam int DEF_OP_W     = 4;
    localparam int DEF_SEL_W    = 9;
    localparam int DEF_CW_W     = 1 + DEF_OP_W + DEF_NUM_REGS + DEF_SEL_W;

    // Field positions inside a control word, counted from bit 0.
    localparam int DEF_LD_LSB   = DEF_SEL_W;
    localparam int DEF_OP_LSB   = DEF_SEL_W + DEF_NUM_REGS;
    localparam int DEF_LAST_BIT = DEF_CW_W - 1;

    typedef struct packed {
        logic                    last;
        logic [DEF_OP_W-1:0]     op;
        logic [DEF_NUM_REGS-1:0] ld;
        logic [DEF_SEL_W-1:0]    sel;
    } cw_t;

endpackage

// File: rtl/lc9_ucode_store.sv
// rtl/lc9_ucode_store.sv - resettable microcode flop array, one write port, async read
module lc9_ucode_store #(
    parameter int AW   = 6,
    parameter int CW_W = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [CW_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [CW_W-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [CW_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lc9_sequencer.sv
// rtl/lc9_sequencer.sv - programmable control sequencer: FSM, step counter, output gating
module lc9_sequencer
    import lc9_seq_pkg::*;
#(
    parameter int NUM_REGS  = 5,
    parameter int OP_W      = 4,
    parameter int SEL_W     = 9,
    parameter int NUM_PROGS = 4,
    parameter int STEPS     = 16,
    localparam int CW_W     = 1 + OP_W + NUM_REGS + SEL_W,
    localparam int MW       = $clog2(NUM_PROGS),
    localparam int SW       = $clog2(STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MW-1:0]       mode,
    input  logic                hold,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SW-1:0]       step,
    output logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] ld,
    output logic [OP_W-1:0]     op,
    input  logic                prog_we,
    input  logic [MW+SW-1:0]    prog_addr,
    input  logic [CW_W-1:0]     prog_wdata
);

    localparam int LD_LSB = SEL_W;
    localparam int OP_LSB = SEL_W + NUM_REGS;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic            err_q, err_d;
    logic [CW_W-1:0] word;

    logic                w_last;
    logic [OP_W-1:0]     w_op;
    logic [NUM_REGS-1:0] w_ld;
    logic [SEL_W-1:0]    w_sel;

    assign w_last = word[CW_W-1];
    assign w_op   = word[OP_LSB +: OP_W];
    assign w_ld   = word[LD_LSB +: NUM_REGS];
    assign w_sel  = word[SEL_W-1:0];

    // Store is only writable while idle, so a running program never sees its words change.
    lc9_ucode_store #(
        .AW   (MW + SW),
        .CW_W (CW_W)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (prog_we && (state_q == IDLE)),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr ({mode_q, step_q}),
        .rdata (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mode_d  = mode_q;
        err_d   = err_q;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        sel     = '0;
        ld      = '0;
        op      = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                sel  = w_sel;
                op   = w_op;
                ld   = (hold || abort) ? '0 : w_ld;
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (hold) begin
                    state_d = RUN;
                end else if (w_last) begin
                    state_d = DONE;
                end else if (step_q == SW'(STEPS - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = !abort;
                err     = !abort && err_q;
                state_d = IDLE;
                step_d  = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step = step_q;

endmodule

// File: tb/tb_lc9_sequencer.sv
// tb/tb_lc9_sequencer.sv - randomized self-checking bench against a step-list reference model
module tb_lc9_sequencer;

    localparam int NUM_REGS  = 5;
    localparam int OP_W      = 4;
    localparam int SEL_W     = 9;
    localparam int NUM_PROGS = 4;
    localparam int STEPS     = 16;
    localparam int CW_W      = 1 + OP_W + NUM_REGS + SEL_W;
    localparam int MW        = 2;
    localparam int SW        = 4;
    localparam int AW        = MW + SW;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [MW-1:0]       mode = '0;
    logic                hold = 1'b0;
    logic                abort = 1'b0;
    logic                prog_we = 1'b0;
    logic [AW-1:0]       prog_addr = '0;
    logic [CW_W-1:0]     prog_wdata = '0;
    logic                busy, done, err;
    logic [SW-1:0]       step;
    logic [SEL_W-1:0]    sel;
    logic [NUM_REGS-1:0] ld;
    logic [OP_W-1:0]     op;

    logic [CW_W-1:0] model [NUM_PROGS*STEPS];
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lc9_sequencer #(
        .NUM_REGS(NUM_REGS), .OP_W(OP_W), .SEL_W(SEL_W), .NUM_PROGS(NUM_PROGS), .STEPS(STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .err(err), .step(step), .sel(sel), .ld(ld), .op(op),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    function automatic logic [CW_W-1:0] mk(input logic last, input int o, input int l, input int s);
        return {last, OP_W'(o), NUM_REGS'(l), SEL_W'(s)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_PROGS*STEPS; i++) model[i] = '0;
    endtask

    task automatic write_word(input int p, input int s, input logic [CW_W-1:0] w);
        prog_we    = 1'b1;
        prog_addr  = AW'(p*STEPS + s);
        prog_wdata = w;
        model[p*STEPS + s] = w;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        vectors++;
        if ({busy, done, err, sel, ld, op} !== '0) begin
            errors++;
            $display("FAIL %s idle: got busy=%b done=%b err=%b sel=%h ld=%h op=%h want all 0",
                     nm, busy, done, err, sel, ld, op);
        end
    endtask

    // Runs program p from an IDLE cycle and checks every cycle against the step list.
    // hold_step >= 0 holds hold_n cycles at that step; -2 holds randomly; -1 never.
    // wr_at 0 writes word 0 together with start; wr_at > 0 attempts a write mid-run.
    task automatic run(input string nm, input int p, input int hold_step, input int hold_n,
                       input int abort_at, input int wr_at, input logic [CW_W-1:0] wr_data,
                       output int bc);
        int s, c, held;
        bit fin, aborted, err_e, h, ab;
        logic [CW_W-1:0] w;
        logic [NUM_REGS-1:0] eld;
        bc = 0; s = 0; c = 0; held = 0; fin = 0; aborted = 0; err_e = 0;
        start = 1'b1;
        mode  = MW'(p);
        if (wr_at == 0) begin
            prog_we    = 1'b1;
            prog_addr  = AW'(p*STEPS);
            prog_wdata = wr_data;
            model[p*STEPS] = wr_data;
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pre-start busy: got %b want 0", nm, busy);
        end
        cyc();
        start   = 1'b0;
        prog_we = 1'b0;
        while (!fin && c < 100) begin
            c++;
            w  = model[p*STEPS + s];
            h  = (hold_step >= 0) ? (s == hold_step && held < hold_n)
               : (hold_step == -2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            ab = (c == abort_at);
            hold  = h;
            abort = ab;
            if (wr_at > 0 && c == wr_at) begin
                prog_we    = 1'b1;
                prog_addr  = AW'(p*STEPS + ((s + 1) % STEPS));
                prog_wdata = ~model[p*STEPS + ((s + 1) % STEPS)];
            end
            @(negedge clk);
            bc += int'(busy);
            eld = (h || ab) ? '0 : w[SEL_W +: NUM_REGS];
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s c%0d handshake: got busy=%b done=%b err=%b want 1 0 0", nm, c, busy, done, err);
            end
            vectors++;
            if (step !== SW'(s)) begin
                errors++;
                $display("FAIL %s c%0d step: got %0d want %0d", nm, c, step, s);
            end
            vectors++;
            if (sel !== w[SEL_W-1:0] || op !== w[SEL_W+NUM_REGS +: OP_W]) begin
                errors++;
                $display("FAIL %s c%0d sel/op: got %h/%h want %h/%h", nm, c, sel, op,
                         w[SEL_W-1:0], w[SEL_W+NUM_REGS +: OP_W]);
            end
            vectors++;
            if (ld !== eld) begin
                errors++;
                $display("FAIL %s c%0d ld: got %h want %h", nm, c, ld, eld);
            end
            cyc();
            prog_we = 1'b0;
            if (ab) begin
                fin = 1; aborted = 1;
            end else if (h) begin
                held++;
            end else if (w[CW_W-1]) begin
                fin = 1;
            end else if (s == STEPS-1) begin
                fin = 1; err_e = 1;
            end else begin
                s++;
            end
        end
        hold  = 1'b0;
        abort = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: run did not finish in %0d cycles", nm, c);
        end
        if (!aborted) begin
            @(negedge clk);
            bc += int'(busy);
            vectors++;
            if (busy !== 1'b1 || done !== 1'b1 || err !== err_e || {sel, ld, op} !== '0) begin
                errors++;
                $display("FAIL %s done cycle: got busy=%b done=%b err=%b outs=%h want 1 1 %b 0",
                         nm, busy, done, err, {sel, ld, op}, err_e);
            end
            cyc();
        end
        #1;
        check_idle(nm);
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, err, step, sel, ld, op} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h want 0", {busy, done, err, step, sel, ld, op});
        end
    endtask

    task automatic load_prog1();
        write_word(1, 0, mk(1'b0, 4'h4, 5'h01, 9'h0A5));
        write_word(1, 1, mk(1'b0, 4'h6, 5'h02, 9'h000));
        write_word(1, 2, mk(1'b1, 4'h0, 5'h10, 9'h000));
    endtask

    task automatic test_basic();
        int bc;
        load_prog1();
        run("basic", 1, -1, 0, -1, -1, '0, bc);
        vectors++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL basic busy_len: got %0d want 4", bc);
        end
    endtask

    task automatic test_hold();
        int bc;
        run("hold", 1, 1, 2, -1, -1, '0, bc);
        vectors++;
        if (bc !== 6) begin
            errors++;
            $display("FAIL hold busy_len: got %0d want 6", bc);
        end
    endtask

    task automatic test_overrun();
        int bc;
        run("overrun", 2, -1, 0, -1, -1, '0, bc);
        vectors++;
        if (bc !== 17) begin
            errors++;
            $display("FAIL overrun busy_len: got %0d want 17", bc);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        run("abort", 1, -1, 0, 2, -1, '0, bc);
        run("after_abort", 1, -1, 0, -1, -1, '0, bc);
        run("b2b", 1, -1, 0, -1, -1, '0, bc);
        vectors++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL b2b busy_len: got %0d want 4", bc);
        end
    endtask

    task automatic test_writes();
        int bc;
        run("wr_busy", 1, -1, 0, -1, 1, '0, bc);
        run("wr_busy_after", 1, -1, 0, -1, -1, '0, bc);
        run("wr_start", 1, -1, 0, -1, 0, mk(1'b0, 4'h9, 5'h0C, 9'h133), bc);
    endtask

    task automatic test_reset_mid_run();
        int bc;
        start = 1'b1;
        mode  = 2'd1;
        cyc();
        start = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, err, step, sel, ld, op} !== '0) begin
            errors++;
            $display("FAIL rst_mid async: got %h want 0", {busy, done, err, step, sel, ld, op});
        end
        clear_model();
        cyc();
        rst_n = 1'b1;
        run("rst_zero", 1, -1, 0, -1, -1, '0, bc);
        vectors++;
        if (bc !== 17) begin
            errors++;
            $display("FAIL rst_zero busy_len: got %0d want 17", bc);
        end
    endtask

    task automatic test_random();
        int bc, p;
        logic [CW_W-1:0] w;
        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(0, NUM_PROGS-1);
            for (int s = 0; s < STEPS; s++) begin
                w = CW_W'($urandom);
                w[CW_W-1] = ($urandom_range(0, 4) == 0);
                write_word(p, s, w);
            end
            run("random", p, -2, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1,
                -1, '0, bc);
        end
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_back_to_back();
        test_writes();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
